// File: rtl/timer_display_scan.sv
// Six-digit multiplexed seven-segment scanner for the stopwatch mm:ss:hh BCD word.
// The time word is snapshotted once per frame. Outputs are registered and include a per-slot anode guard.
module timer_display_scan #(
   parameter int SCAN_DIV = 50000,
   parameter int GUARD    = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] data_in,
   input  logic        hold,
   input  logic        blank_lz,
   output logic [5:0]  an_n,
   output logic [6:0]  seg_n,
   output logic        dp_n,
   output logic        frame_start
);

   localparam int            CW        = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = 7'b0111111;
      endcase
      return seg;
   endfunction

   logic [CW-1:0] scan_cnt_r;
   logic [2:0]    digit_r;
   logic [23:0]   shadow_r;
   logic          wrap_s;
   logic          frame_end_s;
   logic [3:0]    nibble_s;
   logic          lz_s;
   logic          dark_s;
   logic [5:0]    an_s;
   logic          dp_s;

   // Slot wrap and frame boundary detection.
   always_comb begin
      wrap_s      = (scan_cnt_r == CNT_LAST);
      frame_end_s = wrap_s && (digit_r == 3'd5);
   end

   // Scan counter, digit pointer and once-per-frame snapshot of the time word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scan_cnt_r  <= '0;
         digit_r     <= 3'd0;
         shadow_r    <= 24'd0;
         frame_start <= 1'b0;
      end else begin
         if (wrap_s) begin
            scan_cnt_r <= '0;
         end else begin
            scan_cnt_r <= scan_cnt_r + CW'(1);
         end
         if (frame_end_s) begin
            digit_r <= 3'd0;
         end else if (wrap_s) begin
            digit_r <= digit_r + 3'd1;
         end else begin
            digit_r <= digit_r;
         end
         if (frame_end_s && !hold) begin
            shadow_r <= data_in;
         end else begin
            shadow_r <= shadow_r;
         end
         frame_start <= frame_end_s;
      end
   end

   // Current slot: nibble, leading-zero status, anode pattern and decimal point.
   always_comb begin
      nibble_s = 4'd0;
      lz_s     = 1'b0;
      an_s     = 6'b111111;
      dp_s     = 1'b1;
      case (digit_r)
         3'd0: begin nibble_s = shadow_r[3:0];   an_s = 6'b111110; end
         3'd1: begin nibble_s = shadow_r[7:4];   an_s = 6'b111101; end
         3'd2: begin nibble_s = shadow_r[11:8];  an_s = 6'b111011; dp_s = 1'b0; lz_s = ~|shadow_r[23:8];  end
         3'd3: begin nibble_s = shadow_r[15:12]; an_s = 6'b110111; lz_s = ~|shadow_r[23:12]; end
         3'd4: begin nibble_s = shadow_r[19:16]; an_s = 6'b101111; dp_s = 1'b0; lz_s = ~|shadow_r[23:16]; end
         3'd5: begin nibble_s = shadow_r[23:20]; an_s = 6'b011111; lz_s = ~|shadow_r[23:20]; end
         default: begin nibble_s = 4'd0; an_s = 6'b111111; dp_s = 1'b1; lz_s = 1'b0; end
      endcase
      dark_s = (scan_cnt_r < CNT_GUARD) || (blank_lz && lz_s);
   end

   // Registered pin drivers; a dark slot turns everything off.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an_n  <= 6'b111111;
         seg_n <= 7'b1111111;
         dp_n  <= 1'b1;
      end else if (dark_s) begin
         an_n  <= 6'b111111;
         seg_n <= 7'b1111111;
         dp_n  <= 1'b1;
      end else begin
         an_n  <= an_s;
         seg_n <= seg_decode(nibble_s);
         dp_n  <= dp_s;
      end
   end

endmodule
